// File: rtl/mod3_pkg.sv
// ============================================================================
// mod3_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the mod-3 serial datapath. The bit serializer and the
// downstream mod-3 FSM both import this package, so the frame-sequencing state
// encoding and the default sizing constants live in one place.
//
// Contents:
//   MOD3_WIDTH     default bits per serialized word
//   MOD3_TICK_DIV  default clk cycles per slow tick
//   ser_state_t    serializer frame-sequencing states
// ============================================================================
package mod3_pkg;

    localparam int MOD3_WIDTH    = 8;
    localparam int MOD3_TICK_DIV = 4000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,   // waiting for a word, load_ready high
        ARMED  = 2'd1,   // word captured, waiting for the first tick
        SHIFT  = 2'd2,   // emitting the remaining bits, one per tick
        FINISH = 2'd3    // last bit out, done pulses on the next tick
    } ser_state_t;

endpackage

// File: rtl/mod3_tick_div.sv
// ============================================================================
// mod3_tick_div
// ----------------------------------------------------------------------------
// Free-running slow-tick divider. A counter runs 0..TICK_DIV-1; tick is high
// for the single clk in which the counter sits at TICK_DIV-1, and the counter
// wraps to 0 on the following edge. tick is combinational from the counter
// so the serializer can act on it in the same cycle.
//
// Parameters:
//   TICK_DIV  clk cycles per tick (>= 2)
//
// Ports:
//   clk    in   system clock, all state changes on posedge
//   reset  in   synchronous, active-high; counter returns to 0
//   tick   out  one-clk-wide pulse every TICK_DIV clks
// ============================================================================
module mod3_tick_div
    import mod3_pkg::*;
#(
    parameter int TICK_DIV = MOD3_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick = (count_q == LAST);

    always_comb begin
        count_d = count_q + CW'(1);
        if (tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mod3_bit_serializer.sv
// ============================================================================
// mod3_bit_serializer
// ----------------------------------------------------------------------------
// Upstream feeder for the mod-3 serial FSM. Accepts a parallel word over a
// valid/ready handshake and shifts it out MSB-first, one bit per slow tick.
// The first bit of each word is flagged with frame_start so the downstream
// FSM can restart per frame, and done pulses one tick after the last bit so
// the downstream remainder can be sampled.
//
// Build option:
//   MOD3_SER_TICKDIV_EN  defined   : internal mod3_tick_div divider drives the
//                                    tick; TICK_DIV sets the bit period.
//                        undefined : divider removed, tick tied to 1 (one bit
//                                    per clk), slow_tick constant 1 and
//                                    TICK_DIV ignored.
//
// Parameters:
//   WIDTH     bits per word (>= 1)
//   TICK_DIV  clk cycles per slow tick (>= 2)
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high
//   load_valid   in   load_data is valid
//   load_ready   out  word can be accepted (state is IDLE)
//   load_data    in   word to serialize
//   sel_out      out  current serial bit, holds between updates
//   bit_strobe   out  one-clk pulse: sel_out has just updated
//   frame_start  out  one-clk pulse with the strobe of the MSB
//   done         out  one-clk pulse one tick after the last bit
//   busy         out  high from word accept until done
//   slow_tick    out  registered tick, one-clk pulse
// ============================================================================
module mod3_bit_serializer
    import mod3_pkg::*;
#(
    parameter int WIDTH    = MOD3_WIDTH,
    parameter int TICK_DIV = MOD3_TICK_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             sel_out,
    output logic             bit_strobe,
    output logic             frame_start,
    output logic             done,
    output logic             busy,
    output logic             slow_tick
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic tick;

    // ------------------------------------------------------------------
    // Tick source
    // ------------------------------------------------------------------
`ifdef MOD3_SER_TICKDIV_EN
    logic slow_tick_q;
    logic slow_tick_d;

    mod3_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        slow_tick_d = tick;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slow_tick_q <= 1'b0;
        end else begin
            slow_tick_q <= slow_tick_d;
        end
    end

    assign slow_tick = slow_tick_q;
`else
    // Without the divider every clk is a tick; the downstream chain is then
    // gated externally, and TICK_DIV only has to stay legal.
    logic tick_div_unused;

    assign tick            = 1'b1;
    assign slow_tick       = 1'b1;
    assign tick_div_unused = (TICK_DIV >= 2);
`endif

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    ser_state_t       state_q,       state_d;
    logic [WIDTH-1:0] shreg_q,       shreg_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic             sel_out_q,     sel_out_d;
    logic             bit_strobe_q,  bit_strobe_d;
    logic             frame_start_q, frame_start_d;
    logic             done_q,        done_d;
    logic             busy_q,        busy_d;

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        cnt_d         = cnt_q;
        sel_out_d     = sel_out_q;
        busy_d        = busy_q;
        // Pulses drop back to 0 unless re-asserted this cycle.
        bit_strobe_d  = 1'b0;
        frame_start_d = 1'b0;
        done_d        = 1'b0;

        case (state_q)
            IDLE: begin
                // A tick coinciding with the accept is deliberately not used;
                // ARMED waits for the next one.
                if (load_valid) begin
                    shreg_d = load_data;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ARMED;
                end
            end

            ARMED: begin
                if (tick) begin
                    sel_out_d     = shreg_q[WIDTH-1];
                    bit_strobe_d  = 1'b1;
                    frame_start_d = 1'b1;
                    shreg_d       = shreg_q << 1;
                    cnt_d         = CNT_W'(1);
                    if (WIDTH == 1) begin
                        state_d = FINISH;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                if (tick) begin
                    sel_out_d    = shreg_q[WIDTH-1];
                    bit_strobe_d = 1'b1;
                    shreg_d      = shreg_q << 1;
                    cnt_d        = cnt_q + CNT_W'(1);
                    // cnt counts bits already emitted; this tick emits the
                    // last one when cnt+1 reaches WIDTH.
                    if (cnt_q == CNT_LAST) begin
                        state_d = FINISH;
                    end
                end
            end

            FINISH: begin
                if (tick) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            cnt_q         <= '0;
            sel_out_q     <= 1'b0;
            bit_strobe_q  <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            cnt_q         <= cnt_d;
            sel_out_q     <= sel_out_d;
            bit_strobe_q  <= bit_strobe_d;
            frame_start_q <= frame_start_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign load_ready  = (state_q == IDLE);
    assign sel_out     = sel_out_q;
    assign bit_strobe  = bit_strobe_q;
    assign frame_start = frame_start_q;
    assign done        = done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mod3_bit_serializer.sv
// ============================================================================
// tb_mod3_bit_serializer
// ----------------------------------------------------------------------------
// Directed bench for mod3_bit_serializer. Two instances share clk/reset:
// u8 (WIDTH=8, TICK_DIV=4) and u1 (WIDTH=1, TICK_DIV=4). The bit period TD
// follows MOD3_SER_TICKDIV_EN: 4 clks with the divider, 1 clk without.
// ============================================================================
module tb_mod3_bit_serializer;

`ifdef MOD3_SER_TICKDIV_EN
    localparam int   TD        = 4;
    localparam logic SLOW_RST  = 1'b0;
`else
    localparam int   TD        = 1;
    localparam logic SLOW_RST  = 1'b1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic       u8_valid = 1'b0;
    logic [7:0] u8_data  = 8'h00;
    logic       u8_ready, u8_sel, u8_strobe, u8_fs, u8_done, u8_busy, u8_slow;

    logic       u1_valid = 1'b0;
    logic [0:0] u1_data  = 1'b0;
    logic       u1_ready, u1_sel, u1_strobe, u1_fs, u1_done, u1_busy, u1_slow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mod3_bit_serializer #(.WIDTH(8), .TICK_DIV(4)) u8 (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (u8_valid),
        .load_ready  (u8_ready),
        .load_data   (u8_data),
        .sel_out     (u8_sel),
        .bit_strobe  (u8_strobe),
        .frame_start (u8_fs),
        .done        (u8_done),
        .busy        (u8_busy),
        .slow_tick   (u8_slow)
    );

    mod3_bit_serializer #(.WIDTH(1), .TICK_DIV(4)) u1 (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (u1_valid),
        .load_ready  (u1_ready),
        .load_data   (u1_data),
        .sel_out     (u1_sel),
        .bit_strobe  (u1_strobe),
        .frame_start (u1_fs),
        .done        (u1_done),
        .busy        (u1_busy),
        .slow_tick   (u1_slow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send8(input logic [7:0] w, input string tag);
        u8_valid = 1'b1;
        u8_data  = w;
        step();
        u8_valid = 1'b0;
        chk({tag, "_busy_after_accept"}, 32'(u8_busy), 32'd1);
        chk({tag, "_ready_after_accept"}, 32'(u8_ready), 32'd0);
    endtask

    // Follows one u8 frame from just after accept until done.
    // first_exact > 0 demands that exact accept-to-first-strobe latency.
    task automatic frame8(input logic [7:0] word, input int first_exact, input string tag);
        logic [7:0] got;
        int         ns, cyc, last, first_lat, done_gap;
        bit         spacing_ok, fs_ok, done_seen, busy_at_done;
        got = 8'h00; ns = 0; cyc = 0; last = 0; first_lat = 0; done_gap = 0;
        spacing_ok = 1'b1; fs_ok = 1'b1; done_seen = 1'b0; busy_at_done = 1'b1;
        for (int i = 0; i < 12 * TD + 20 && !done_seen; i++) begin
            step();
            cyc++;
            if (u8_strobe) begin
                if (ns == 0) first_lat = cyc;
                else if (cyc - last != TD) spacing_ok = 1'b0;
                if (u8_fs !== (ns == 0)) fs_ok = 1'b0;
                got  = {got[6:0], u8_sel};
                ns++;
                last = cyc;
            end else if (u8_fs) begin
                fs_ok = 1'b0;
            end
            if (u8_done) begin
                done_seen    = 1'b1;
                done_gap     = cyc - last;
                busy_at_done = u8_busy;
            end
        end
        chk({tag, "_done_seen"}, 32'(done_seen), 32'd1);
        chk({tag, "_bits"}, 32'(got), 32'(word));
        chk({tag, "_strobes"}, 32'(ns), 32'd8);
        chk({tag, "_spacing"}, 32'(spacing_ok), 32'd1);
        chk({tag, "_frame_start"}, 32'(fs_ok), 32'd1);
        chk({tag, "_done_gap"}, 32'(done_gap), 32'(TD));
        chk({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
        chk({tag, "_sel_hold"}, 32'(u8_sel), 32'(word[0]));
        if (first_exact > 0)
            chk({tag, "_first_lat"}, 32'(first_lat), 32'(first_exact));
        else
            chk({tag, "_first_lat_range"}, 32'(first_lat >= 1 && first_lat <= TD), 32'd1);
    endtask

    initial begin
        int  nslow, nbad, cnt;
        bit  seen;

        // ---------------- reset ----------------
        reset = 1'b1;
        repeat (3) step();
        chk("rst_ready", 32'(u8_ready), 32'd1);
        chk("rst_sel", 32'(u8_sel), 32'd0);
        chk("rst_outputs", 32'({u8_strobe, u8_fs, u8_done, u8_busy}), 32'd0);
        chk("rst_slow", 32'(u8_slow), 32'(SLOW_RST));
        chk("rst_u1_ready", 32'(u1_ready), 32'd1);
        chk("rst_u1_outputs", 32'({u1_sel, u1_strobe, u1_fs, u1_done, u1_busy}), 32'd0);
        reset = 1'b0;
        nslow = 0; nbad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (u8_slow) nslow++;
            if (u8_strobe || u8_fs || u8_done || u8_busy || !u8_ready) nbad++;
        end
        chk("idle_no_activity", 32'(nbad), 32'd0);
        chk("idle_slow_ticks", 32'(nslow), 32'(20 / TD));

        // ---------------- basic frame ----------------
        send8(8'hB4, "basic");
        frame8(8'hB4, 0, "basic");

        // ---------------- tick collision ----------------
        seen = 1'b0;
        for (int i = 0; i < 4 * TD + 4 && !seen; i++) begin
            step();
            if (u8_slow) seen = 1'b1;
        end
        chk("coll_slow_seen", 32'(seen), 32'd1);
        repeat (TD - 1) step();
        send8(8'h96, "coll");
        frame8(8'h96, TD, "coll");

        // ---------------- stall: load_valid held through the frame ----------------
        send8(8'h3C, "stall");
        u8_valid = 1'b1;
        u8_data  = 8'hFF;
        frame8(8'h3C, 0, "stall");
        chk("stall_ready_on_done", 32'(u8_ready), 32'd1);
        step();
        u8_valid = 1'b0;
        chk("stall_next_busy", 32'(u8_busy), 32'd1);
        frame8(8'hFF, 0, "next");

        // ---------------- reset mid-frame ----------------
        send8(8'hA5, "abort");
        cnt = 0;
        for (int i = 0; i < 8 * TD + 8 && cnt < 3; i++) begin
            step();
            if (u8_strobe) cnt++;
        end
        chk("abort_three_bits", 32'(cnt), 32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_ready", 32'(u8_ready), 32'd1);
        chk("abort_state", 32'({u8_busy, u8_sel, u8_strobe, u8_done}), 32'd0);
        nbad = 0;
        for (int i = 0; i < 12 * TD + 4; i++) begin
            step();
            if (u8_done || u8_strobe || u8_busy) nbad++;
        end
        chk("abort_no_done", 32'(nbad), 32'd0);
        send8(8'h03, "after_abort");
        frame8(8'h03, 0, "after_abort");

        // ---------------- WIDTH=1 with back-to-back accept ----------------
        u1_valid = 1'b1;
        u1_data  = 1'b1;
        step();
        u1_valid = 1'b0;
        chk("w1_busy", 32'(u1_busy), 32'd1);
        cnt = 0; seen = 1'b0;
        for (int i = 0; i < TD + 4 && !seen; i++) begin
            step();
            cnt++;
            if (u1_strobe) seen = 1'b1;
        end
        chk("w1_first_lat", 32'(cnt >= 1 && cnt <= TD), 32'd1);
        chk("w1_bit", 32'({u1_strobe, u1_fs, u1_sel}), 32'b111);
        cnt = 0; seen = 1'b0;
        for (int i = 0; i < TD + 4 && !seen; i++) begin
            step();
            cnt++;
            if (u1_done) seen = 1'b1;
        end
        chk("w1_done_gap", 32'(cnt), 32'(TD));
        chk("w1_done_state", 32'({u1_done, u1_busy, u1_ready}), 32'b101);
        // accept on the done cycle
        u1_valid = 1'b1;
        u1_data  = 1'b0;
        step();
        u1_valid = 1'b0;
        chk("w1_b2b_busy", 32'(u1_busy), 32'd1);
        cnt = 0; seen = 1'b0;
        for (int i = 0; i < TD + 4 && !seen; i++) begin
            step();
            cnt++;
            if (u1_strobe) seen = 1'b1;
        end
        chk("w1_b2b_first_lat", 32'(cnt >= 1 && cnt <= TD), 32'd1);
        chk("w1_b2b_bit", 32'({u1_strobe, u1_fs, u1_sel}), 32'b110);
        cnt = 0; seen = 1'b0;
        for (int i = 0; i < TD + 4 && !seen; i++) begin
            step();
            cnt++;
            if (u1_done) seen = 1'b1;
        end
        chk("w1_b2b_done_gap", 32'(cnt), 32'(TD));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod3_bit_serializer.md
# mod3_bit_serializer

- Upstream feeder for the mod-3 serial FSM.
- Accepts a parallel word through a valid/ready handshake and shifts it out MSB-first, one bit per slow tick.
- Marks the first bit of each word and signals completion, so the downstream FSM can be reset per frame and its remainder sampled after the last bit.
- Owns the slow-tick divider, so the whole stage runs on one clock.

## Interface
- WIDTH, 8: bits per word, ≥1.
- TICK_DIV, 4000000: clk cycles per slow tick, ≥2 (used only when the divider is compiled in).
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- load_valid  in  1  load_data is valid.
- load_ready  out  1  block can accept a word; equals (state==IDLE).
- load_data  in  WIDTH  word to serialize.
- sel_out  out  1  current serial bit; drives the downstream FSM's bit input.
- bit_strobe  out  1  one-clk pulse: sel_out has just updated.
- frame_start  out  1  one-clk pulse coinciding with bit_strobe of the first (MSB) bit.
- done  out  1  one-clk pulse, one tick after the last bit.
- busy  out  1  high from word accept until done.
- slow_tick  out  1  one-clk tick pulse, exported for downstream use.

## Operation
- **Tick**
  - Free-running counter, 0..TICK_DIV-1, width $clog2(TICK_DIV).
  - tick=1 in the cycle where counter==TICK_DIV-1; the counter wraps to 0 on the next edge.
  - slow_tick is tick registered (one-clk pulse).
- **States:** IDLE, ARMED, SHIFT, FINISH.
- **IDLE**
  - load_ready=1.
  - On load_valid: capture load_data into shreg, set cnt=0, busy<=1, go to ARMED.
- **ARMED**
  - On tick: sel_out<=shreg[WIDTH-1], bit_strobe<=1, frame_start<=1, shreg<<=1, cnt<=1.
  - If WIDTH==1, go to FINISH; else go to SHIFT.
- **SHIFT**
  - On tick: sel_out<=shreg[WIDTH-1], bit_strobe<=1, shreg<<=1, cnt<=cnt+1.
  - When cnt+1==WIDTH, go to FINISH.
- **FINISH**
  - On tick: done<=1, busy<=0, go to IDLE.
- **Output hold rules**
  - sel_out holds its value between updates; it holds the last bit after FINISH and is not cleared.
  - bit_strobe, frame_start and done are high for exactly one clk.
  - cnt is $clog2(WIDTH+1) bits wide and never exceeds WIDTH.
- **Boundary conditions**
  - A tick in the same cycle as accept is ignored; the first bit comes on the first tick strictly after accept.
  - load_valid while load_ready=0 is ignored; the word is not captured, and the bench must hold it.
  - Accept is allowed in the same cycle as done is high, because the state is already IDLE.
  - Reset mid-frame abandons the frame: no done pulse, counter to 0, state to IDLE.

## Timing
- **Reset values:**
  - sel_out=0, bit_strobe=0, frame_start=0, done=0, busy=0, slow_tick=0.
  - load_ready=1, state=IDLE, counter=0, shreg=0, cnt=0.
- **Latency from accept:**
  - First bit on the first tick after accept: ≤TICK_DIV clks later, plus one register stage.
  - Bit k (0-based) appears k ticks after the first bit.
  - done appears one tick after bit WIDTH-1.
- **Word period:** WIDTH+1 ticks, plus the wait for the first tick.

## Configuration
- **MOD3_SER_TICKDIV_EN defined:** internal divider active as described; TICK_DIV applies.
- **Not defined:**
  - Divider removed; tick is tied to 1, so one bit is emitted per clk.
  - slow_tick is constant 1 and TICK_DIV is ignored.
  - Used for fast simulation and for chaining with an external enable.

## Structure
- **Package mod3_pkg** holds:
  - the state enum ser_state_t (IDLE, ARMED, SHIFT, FINISH);
  - default constants MOD3_WIDTH=8 and MOD3_TICK_DIV=4000000.
  - The downstream FSM reuses the same package.
- **One sub-module, mod3_tick_div:** parameter TICK_DIV; ports clk, reset, tick. Instantiated only under MOD3_SER_TICKDIV_EN.

## Test plan
- **Reset:** WIDTH=8, TICK_DIV=4, macro on; assert reset 3 clks → load_ready=1, all other outputs 0, and no strobes for 20 clks.
- **Basic frame:** load_data=8'hB4 accepted → sel_out sequence 1,0,1,1,0,1,0,0 with 8 strobes spaced 4 clks apart; frame_start only on the first; done 4 clks after the last strobe; busy low with done.
- **Tick collision and stall:**
  - Accept in the cycle where tick=1 → no bit on that tick; first strobe 4 clks later.
  - load_valid held during the frame with data 8'hFF → ignored; the next frame starts only after done.
- **Reset mid-frame:** reset after 3 bits of 8'hA5 → no done; a new word 8'h03 then serializes fully as 0,0,0,0,0,0,1,1.
- **Macro off, WIDTH=1:** load 1'b1 → strobe with frame_start on the next clk; done on the clk after that; back-to-back accept on the done cycle works.
